// File: rtl/md5_match_tracker.sv
// md5_match_tracker: multi-lane MD5 brute-force match tracker.
// A LATENCY-deep delay line carries each candidate text beside its MD5 core, so the
// reported text is the one whose digest matched. A host command port programs the
// target digest and the generator range, starts a run and reads back count and match.
module md5_match_tracker #(
    parameter int LANES   = 1,
    parameter int TEXT_W  = 128,
    parameter int LATENCY = 64,
    parameter int CNT_W   = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    input  logic [31:0]               cmd_data,
    output logic [31:0]               rsp_data,
    output logic                      rsp_valid,
    output logic                      gen_reset,
    output logic                      gen_enable,
    output logic [7:0]                range_min,
    output logic [7:0]                range_max,
    input  logic                      cand_valid,
    input  logic [LANES*TEXT_W-1:0]   cand_text,
    input  logic [LANES*128-1:0]      dig_in,
    output logic                      matched,
    output logic [TEXT_W-1:0]         match_text,
    output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] match_lane,
    output logic [CNT_W-1:0]          match_count
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int NW = TEXT_W / 32;

    localparam logic [31:0] CMD_RESET_GEN = 32'h5230_0000;
    localparam logic [31:0] CMD_START     = 32'h5230_0001;
    localparam logic [31:0] CMD_TGT_A     = 32'h5230_1000;
    localparam logic [31:0] CMD_TGT_B     = 32'h5230_1001;
    localparam logic [31:0] CMD_TGT_C     = 32'h5230_1002;
    localparam logic [31:0] CMD_TGT_D     = 32'h5230_1003;
    localparam logic [31:0] CMD_RANGE     = 32'h5230_2000;
    localparam logic [31:0] CMD_CNT_LO    = 32'h5230_3000;
    localparam logic [31:0] CMD_CNT_HI    = 32'h5230_3001;
    localparam logic [31:0] CMD_STATUS    = 32'h5230_3002;
    localparam logic [31:0] CMD_TEXT_W0   = 32'h4400_0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FOUND = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ARG_NONE  = 3'd0,
        ARG_TA    = 3'd1,
        ARG_TB    = 3'd2,
        ARG_TC    = 3'd3,
        ARG_TD    = 3'd4,
        ARG_RANGE = 3'd5
    } arg_t;

    state_t                    state_q, state_d;
    arg_t                      arg_q, arg_d;
    logic [127:0]              target_q, target_d;
    logic [7:0]                range_min_q, range_min_d;
    logic [7:0]                range_max_q, range_max_d;
    logic [31:0]               rsp_data_q, rsp_data_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      matched_q, matched_d;
    logic [TEXT_W-1:0]         match_text_q, match_text_d;
    logic [LW-1:0]             match_lane_q, match_lane_d;
    logic [CNT_W-1:0]          match_count_q, match_count_d;

    logic                      dly_vld_q  [LATENCY];
    logic                      dly_vld_d  [LATENCY];
    logic [LANES*TEXT_W-1:0]   dly_text_q [LATENCY];
    logic [LANES*TEXT_W-1:0]   dly_text_d [LATENCY];

    logic                      rst_gen;
    logic                      start;
    logic                      retire;
    logic                      hit_any;
    logic [LW-1:0]             win_lane;
    logic [TEXT_W-1:0]         win_text;
    logic [63:0]               count_ext;

    assign count_ext = 64'(count_q);
    assign retire    = dly_vld_q[LATENCY-1] && (state_q == ST_RUN);

    // Lowest-numbered lane whose digest equals the target wins the retire
    always_comb begin
        hit_any  = 1'b0;
        win_lane = '0;
        win_text = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (dig_in[l*128 +: 128] == target_q) begin
                hit_any  = 1'b1;
                win_lane = LW'(l);
                win_text = dly_text_q[LATENCY-1][l*TEXT_W +: TEXT_W];
            end
        end
    end

    // Host command decode: argument capture, responses, and control strobes
    always_comb begin
        arg_d       = arg_q;
        target_d    = target_q;
        range_min_d = range_min_q;
        range_max_d = range_max_q;
        rsp_valid_d = cmd_valid;
        rsp_data_d  = 32'h0;
        rst_gen     = 1'b0;
        start       = 1'b0;
        if (cmd_valid) begin
            if (arg_q != ARG_NONE) begin
                // The word after a set command is always taken as its argument
                case (arg_q)
                    ARG_TA:    target_d[31:0]   = cmd_data;
                    ARG_TB:    target_d[63:32]  = cmd_data;
                    ARG_TC:    target_d[95:64]  = cmd_data;
                    ARG_TD:    target_d[127:96] = cmd_data;
                    ARG_RANGE: begin
                        range_min_d = cmd_data[7:0];
                        range_max_d = cmd_data[15:8];
                    end
                    default:   ;
                endcase
                arg_d = ARG_NONE;
            end else begin
                case (cmd_data)
                    CMD_RESET_GEN: rst_gen = 1'b1;
                    CMD_START:     start   = 1'b1;
                    CMD_TGT_A:     arg_d   = ARG_TA;
                    CMD_TGT_B:     arg_d   = ARG_TB;
                    CMD_TGT_C:     arg_d   = ARG_TC;
                    CMD_TGT_D:     arg_d   = ARG_TD;
                    CMD_RANGE:     arg_d   = ARG_RANGE;
                    CMD_CNT_LO:    rsp_data_d = count_ext[31:0];
                    CMD_CNT_HI:    rsp_data_d = count_ext[63:32];
                    CMD_STATUS:    rsp_data_d = {16'h0, 8'(match_lane_q), 5'h0, state_q, matched_q};
                    default: begin
                        for (int i = 0; i < NW; i++) begin
                            if (cmd_data == CMD_TEXT_W0 + 32'(i)) begin
                                rsp_data_d = match_text_q[i*32 +: 32];
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Run-control FSM, retire counting and first-match capture
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        matched_d     = matched_q;
        match_text_d  = match_text_q;
        match_lane_d  = match_lane_q;
        match_count_d = match_count_q;
        if (start && (state_q == ST_IDLE)) begin
            state_d = ST_RUN;
        end
        if (retire) begin
            count_d = count_q + CNT_W'(LANES);
            if (hit_any) begin
                matched_d     = 1'b1;
                match_text_d  = win_text;
                match_lane_d  = win_lane;
                match_count_d = count_q + CNT_W'(win_lane);
                state_d       = ST_FOUND;
            end
        end
        // Rearm overrides a hit landing in the same cycle
        if (rst_gen) begin
            state_d       = ST_IDLE;
            count_d       = '0;
            matched_d     = 1'b0;
            match_text_d  = '0;
            match_lane_d  = '0;
            match_count_d = '0;
        end
    end

    // Delay line next values: valid gated by RUN, texts shift unconditionally
    always_comb begin
        dly_vld_d[0]  = cand_valid && (state_q == ST_RUN);
        dly_text_d[0] = cand_text;
        for (int i = 1; i < LATENCY; i++) begin
            dly_vld_d[i]  = dly_vld_q[i-1];
            dly_text_d[i] = dly_text_q[i-1];
        end
        if (rst_gen) begin
            for (int i = 0; i < LATENCY; i++) begin
                dly_vld_d[i] = 1'b0;
            end
        end
    end

    // Control and captured-result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            arg_q         <= ARG_NONE;
            target_q      <= '0;
            range_min_q   <= 8'h61;
            range_max_q   <= 8'h7a;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            count_q       <= '0;
            matched_q     <= 1'b0;
            match_text_q  <= '0;
            match_lane_q  <= '0;
            match_count_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dly_vld_q[i] <= 1'b0;
            end
        end else begin
            state_q       <= state_d;
            arg_q         <= arg_d;
            target_q      <= target_d;
            range_min_q   <= range_min_d;
            range_max_q   <= range_max_d;
            rsp_data_q    <= rsp_data_d;
            rsp_valid_q   <= rsp_valid_d;
            count_q       <= count_d;
            matched_q     <= matched_d;
            match_text_q  <= match_text_d;
            match_lane_q  <= match_lane_d;
            match_count_q <= match_count_d;
            for (int i = 0; i < LATENCY; i++) begin
                dly_vld_q[i] <= dly_vld_d[i];
            end
        end
    end

    // Text delay line, aligned stage-for-stage with the MD5 cores
    always_ff @(posedge clk) begin
        for (int i = 0; i < LATENCY; i++) begin
            dly_text_q[i] <= dly_text_d[i];
        end
    end

    assign rsp_data    = rsp_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign gen_reset   = (state_q == ST_IDLE);
    assign gen_enable  = (state_q == ST_RUN);
    assign range_min   = range_min_q;
    assign range_max   = range_max_q;
    assign matched     = matched_q;
    assign match_text  = match_text_q;
    assign match_lane  = match_lane_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_md5_match_tracker.sv
// Bench for md5_match_tracker: unit A (1 lane, 128-bit text, 64-bit count) and
// unit B (4 lanes, 64-bit text, 33-bit count), both with a 4-cycle core model.
module tb_md5_match_tracker;

    localparam logic [31:0] RESET_GEN = 32'h5230_0000;
    localparam logic [31:0] START     = 32'h5230_0001;
    localparam logic [31:0] TGT_A     = 32'h5230_1000;
    localparam logic [31:0] RANGE     = 32'h5230_2000;
    localparam logic [31:0] CNT_LO    = 32'h5230_3000;
    localparam logic [31:0] CNT_HI    = 32'h5230_3001;
    localparam logic [31:0] STATUS    = 32'h5230_3002;
    localparam logic [31:0] TXT1      = 32'h4400_0001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // unit A
    logic         cva, rva, gra, gea, cav, ma;
    logic [31:0]  cda, rda;
    logic [7:0]   rmina, rmaxa;
    logic [127:0] cat, diga, mta;
    logic [0:0]   mla;
    logic [63:0]  mca;
    // unit B
    logic         cvb, rvb, grb, geb, cbv, mb;
    logic [31:0]  cdb, rdb;
    logic [7:0]   rminb, rmaxb;
    logic [255:0] cbt;
    logic [511:0] digb;
    logic [63:0]  mtb;
    logic [1:0]   mlb;
    logic [32:0]  mcb;

    md5_match_tracker #(.LANES(1), .TEXT_W(128), .LATENCY(4), .CNT_W(64)) u_a (
        .clk(clk), .reset(rst), .cmd_valid(cva), .cmd_data(cda), .rsp_data(rda),
        .rsp_valid(rva), .gen_reset(gra), .gen_enable(gea), .range_min(rmina),
        .range_max(rmaxa), .cand_valid(cav), .cand_text(cat), .dig_in(diga),
        .matched(ma), .match_text(mta), .match_lane(mla), .match_count(mca));

    md5_match_tracker #(.LANES(4), .TEXT_W(64), .LATENCY(4), .CNT_W(33)) u_b (
        .clk(clk), .reset(rst), .cmd_valid(cvb), .cmd_data(cdb), .rsp_data(rdb),
        .rsp_valid(rvb), .gen_reset(grb), .gen_enable(geb), .range_min(rminb),
        .range_max(rmaxb), .cand_valid(cbv), .cand_text(cbt), .dig_in(digb),
        .matched(mb), .match_text(mtb), .match_lane(mlb), .match_count(mcb));

    // Core model: 4-cycle delay of {4{text[31:0] ^ A5A5A5A5}} per lane
    logic [127:0] pa [4];
    logic [511:0] pb [4];
    always @(posedge clk) begin
        pa[0] <= {4{cat[31:0] ^ 32'hA5A5_A5A5}};
        for (int l = 0; l < 4; l++) begin
            pb[0][l*128 +: 128] <= {4{cbt[l*64 +: 32] ^ 32'hA5A5_A5A5}};
        end
        for (int i = 1; i < 4; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign diga = pa[3];
    assign digb = pb[3];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One command word to unit u (0=A, 1=B); returns the response word
    task automatic cmd(input int u, input logic [31:0] w, output logic [31:0] r);
        @(negedge clk);
        if (u == 0) begin cva = 1'b1; cda = w; end
        else        begin cvb = 1'b1; cdb = w; end
        @(negedge clk);
        cva = 1'b0;
        cvb = 1'b0;
        r = (u == 0) ? rda : rdb;
        chk("rsp_valid", (u == 0) ? rva : rvb, 1'b1);
    endtask

    task automatic set_target(input int u, input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            cmd(u, TGT_A + 32'(k), r);
            cmd(u, w, r);
        end
    endtask

    logic [31:0] r;

    initial begin
        rst = 1'b1;
        cva = 1'b0; cda = '0; cav = 1'b0; cat = '0;
        cvb = 1'b0; cdb = '0; cbv = 1'b0; cbt = '0;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", rva, 1'b0);
        chk("rst_rsp_data", rda, 32'h0);
        chk("rst_gen_reset", gra, 1'b1);
        chk("rst_gen_enable", gea, 1'b0);
        chk("rst_range_min", rmina, 8'h61);
        chk("rst_range_max", rmaxa, 8'h7a);
        chk("rst_matched", ma, 1'b0);
        chk("rst_match_count", mca, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single lane: target matches text 0x61616164 (4th candidate)
        set_target(0, 32'hC4C4_C4C1);
        cmd(0, START, r);
        chk("run_gen_enable", gea, 1'b1);
        chk("run_gen_reset", gra, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("no_match_yet", ma, 1'b0);
            cav = 1'b1;
            cat = {32'hDEAD_0000 + 32'(i), 64'h0, 32'h6161_6161 + 32'(i)};
            @(negedge clk);
        end
        cav = 1'b0;
        chk("match_timing", ma, 1'b1);
        repeat (6) @(negedge clk);
        chk("a_matched", ma, 1'b1);
        chk("a_match_count", mca, 64'd3);
        chk("a_match_lane", mla, 1'b0);
        chk("a_found_gen_enable", gea, 1'b0);
        chk("a_found_gen_reset", gra, 1'b0);
        cmd(0, TXT1, r);      chk("a_text_w1", r, 32'h6161_6164);
        cmd(0, TXT1 + 3, r);  chk("a_text_w4", r, 32'hDEAD_0003);
        cmd(0, TXT1 + 4, r);  chk("a_text_w5_beyond", r, 32'h0);
        cmd(0, STATUS, r);    chk("a_status_found", r, 32'h0000_0005);

        // Range write, then the following word is a command again
        cmd(0, RANGE, r);
        cmd(0, 32'h0000_7a41, r);  chk("range_set_rsp", r, 32'h0);
        chk("range_min", rmina, 8'h41);
        chk("range_max", rmaxa, 8'h7a);
        cmd(0, STATUS, r);    chk("after_range_decoded", r, 32'h0000_0005);
        cmd(0, START, r);
        cmd(0, STATUS, r);    chk("start_in_found_ignored", r, 32'h0000_0005);

        cmd(0, RESET_GEN, r);
        chk("rg_matched", ma, 1'b0);
        chk("rg_gen_reset", gra, 1'b1);
        chk("rg_match_count", mca, 64'h0);
        chk("rg_range_kept", rmina, 8'h41);
        cmd(0, CNT_LO, r);    chk("rg_count", r, 32'h0);

        // Ten retires without a hit
        cmd(0, START, r);
        for (int i = 0; i < 10; i++) begin
            cav = 1'b1;
            cat = {96'h0, 32'h7000_0000 + 32'(i)};
            @(negedge clk);
        end
        cav = 1'b0;
        repeat (8) @(negedge clk);
        cmd(0, CNT_LO, r);    chk("count10_lo", r, 32'd10);
        cmd(0, CNT_HI, r);    chk("count10_hi", r, 32'd0);
        chk("count10_no_match", ma, 1'b0);
        cmd(0, RESET_GEN, r);
        cmd(0, CNT_LO, r);    chk("count_cleared", r, 32'd0);
        chk("count_cleared_matched", ma, 1'b0);

        // RESET_GEN lands on the same edge as a hit
        cmd(0, START, r);
        @(negedge clk);
        cav = 1'b1;
        cat = {96'h0, 32'h6161_6164};
        @(negedge clk);
        cav = 1'b0;
        repeat (3) @(negedge clk);
        cva = 1'b1;
        cda = RESET_GEN;
        @(negedge clk);
        cva = 1'b0;
        chk("race_matched", ma, 1'b0);
        chk("race_gen_reset", gra, 1'b1);
        repeat (5) @(negedge clk);
        chk("race_no_stale", ma, 1'b0);
        cmd(0, STATUS, r);    chk("race_status", r, 32'h0);

        // Four lanes: lanes 1 and 3 hit on the third retire
        set_target(1, 32'hB4B4_A5A5);
        cmd(1, START, r);
        for (int k = 0; k < 3; k++) begin
            cbv = 1'b1;
            for (int l = 0; l < 4; l++) begin
                cbt[l*64 +: 32] = (k == 2 && (l == 1 || l == 3)) ? 32'h1111_0000
                                  : 32'h2000_0000 + 32'(k*16 + l);
                cbt[l*64+32 +: 32] = {16'hC0DE, 8'(k), 8'(l)};
            end
            @(negedge clk);
        end
        cbv = 1'b0;
        repeat (8) @(negedge clk);
        chk("b_matched", mb, 1'b1);
        chk("b_match_lane", mlb, 2'd1);
        chk("b_match_count", mcb, 33'd9);
        chk("b_gen_enable", geb, 1'b0);
        cmd(1, TXT1, r);      chk("b_text_w1", r, 32'h1111_0000);
        cmd(1, TXT1 + 1, r);  chk("b_text_w2", r, 32'hC0DE_0201);
        cmd(1, TXT1 + 2, r);  chk("b_text_w3_beyond", r, 32'h0);
        cmd(1, STATUS, r);    chk("b_status", r, 32'h0000_0105);
        cmd(1, RESET_GEN, r);
        chk("b_rg_matched", mb, 1'b0);

        // 33-bit counter preloaded near wrap
        @(negedge clk);
        force u_b.count_q = 33'h1_FFFF_FFF8;
        @(posedge clk);
        #1;
        release u_b.count_q;
        @(negedge clk);
        cmd(1, CNT_HI, r);    chk("wrap_pre_hi", r, 32'd1);
        cmd(1, CNT_LO, r);    chk("wrap_pre_lo", r, 32'hFFFF_FFF8);
        cmd(1, START, r);
        for (int k = 0; k < 2; k++) begin
            cbv = 1'b1;
            for (int l = 0; l < 4; l++) begin
                cbt[l*64 +: 64] = {32'h0, 32'h3000_0000 + 32'(k*4 + l)};
            end
            @(negedge clk);
        end
        cbv = 1'b0;
        repeat (8) @(negedge clk);
        cmd(1, CNT_LO, r);    chk("wrap_lo", r, 32'd0);
        cmd(1, CNT_HI, r);    chk("wrap_hi", r, 32'd0);
        chk("wrap_no_match", mb, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
